// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor types and widths for the resolve queue and predictor
package bp_pkg;
  localparam int XLEN = 32;
  localparam int IDX_W = 8;
  localparam int BQ_DEPTH = 8;
  typedef enum logic [1:0] {BP_SNT, BP_WNT, BP_WT, BP_ST} bp_counter_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } bq_entry_t;
  function automatic logic [IDX_W-1:0] bp_index(input logic [XLEN-1:0] pc);
    return pc[IDX_W-1:0];
  endfunction
endpackage

// File: rtl/bp_queue_mem.sv
// bp_queue_mem: DEPTH-entry branch queue storage, one write port, one async read port
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write slot
//   i_wdata  in   entry written
//   i_raddr  in   read slot
//   o_rdata  out  entry at i_raddr (combinational)
module bp_queue_mem
  import bp_pkg::*;
#(
  parameter int DEPTH = BQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  bq_entry_t                i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output bq_entry_t                o_rdata
);
  bq_entry_t r_mem [DEPTH];
  always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: in-order queue of in-flight predicted branches; resolves the head,
// drives the predictor update port and raises a mispredict redirect.
//   clk, rst_n                        clock, async active-low reset
//   alloc_valid/ready/pc/pred_*       fetch push (ready = not full)
//   res_valid/taken/target            execute resolves the oldest entry
//   flush                             discard all queued entries
//   upd_we/addr/taken                 registered predictor update, one cycle after resolve
//   mispredict/redirect_pc            registered redirect pulse and correct next PC
//   count                             occupancy
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = BQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [XLEN-1:0]            alloc_pc,
  input  logic                       alloc_pred_taken,
  input  logic [XLEN-1:0]            alloc_pred_target,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [XLEN-1:0]            res_target,
  input  logic                       flush,
  output logic                       upd_we,
  output logic [IDX_W-1:0]           upd_addr,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic [XLEN-1:0]            redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  bq_entry_t     w_head;
  logic          w_res_acc, w_mis, w_push, w_clear;
  bp_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_tail),
    .i_wdata ('{pc: alloc_pc, pred_taken: alloc_pred_taken, pred_target: alloc_pred_target}),
    .i_raddr (r_head),
    .o_rdata (w_head)
  );
  assign alloc_ready = r_count != CW'(DEPTH);
  assign w_res_acc   = res_valid && r_count != '0;
  assign w_mis       = w_res_acc && (w_head.pred_taken != res_taken ||
                       (res_taken && w_head.pred_target != res_target));
  // a mispredict or flush means anything fetched this cycle is on the wrong path
  assign w_clear     = w_mis || flush;
  assign w_push      = alloc_valid && alloc_ready && !w_clear;
  assign count       = r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      upd_we      <= 1'b0;
      upd_addr    <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      r_head     <= w_clear ? '0 : r_head + PW'(w_res_acc);
      r_tail     <= w_clear ? '0 : r_tail + PW'(w_push);
      r_count    <= w_clear ? '0 : r_count + CW'(w_push) - CW'(w_res_acc);
      upd_we     <= w_res_acc;
      mispredict <= w_mis;
      if (w_res_acc) begin
        upd_addr  <= bp_index(w_head.pc);
        upd_taken <= res_taken;
      end
      if (w_mis) redirect_pc <= res_taken ? res_target : w_head.pc + XLEN'(4);
    end
  end
endmodule
